memory_arbiter: RTL and testbench

Arbitrates the dcache and icache miss/writeback traffic onto the single-ported RAM. Sits directly downstream of the dcache controller and icache: it consumes their `dREN`/`dWEN`/`iREN` requests and returns the `dwait`/`iwait` handshakes they sequence on. Data requests have priority. A starvation counter guarantees instruction fetch progress during long dcache bursts such as flush and writeback sequences.

---
 rtl/memory_arbiter_if.sv | 37 +++
 rtl/memory_arbiter.sv | 126 ++++++++++++
 tb/tb_memory_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
// Bus bundle between the dcache/icache, the arbiter and the single-ported RAM.
//   dcache side : dREN, dWEN, daddr, dstore -> arbiter; dwait, dload <- arbiter
//   icache side : iREN, iaddr -> arbiter; iwait, iload <- arbiter
//   RAM side    : ramREN, ramWEN, ramaddr, ramstore <- arbiter; ramload, ramstate -> arbiter
// slave  : the arbiter's view (takes cache requests, drives the RAM).
// master : the environment's view (caches and RAM together).
interface memory_arbiter_if;
  // dcache
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  // icache
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  // RAM
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport slave (
    input  dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
    output dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
    input  dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/memory_arbiter.sv
// Arbitrates dcache and icache traffic onto one single-ported RAM.
// Data requests win; after STARVE_LIMIT data completions with an icache
// request pending, one instruction access is forced.
// Ports:
//   CLK  : clock, rising edge
//   nRST : asynchronous active-low reset
//   bus  : memory_arbiter_if.slave (cache requests in, RAM controls out)
// RAM controls and the wait handshakes are combinational from the owner
// state and ramstate, so completion is visible in the ACCESS cycle itself
// and a reset drops the enables without waiting for a clock.
// STARVE_LIMIT must be at least 1.
module memory_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic             CLK,
  input logic             nRST,
  memory_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             d_req;
  logic             ram_done;
  logic             starved;

  // Read data goes straight through to both caches.
  assign bus.dload = bus.ramload;
  assign bus.iload = bus.ramload;

  assign d_req    = bus.dREN | bus.dWEN;
  // BUSY, FREE and ERROR all mean "not done yet"; only ACCESS completes.
  assign ram_done = (bus.ramstate == RAM_ACCESS);
  assign starved  = (starve_cnt_q == CNT_MAX);
  assign cnt_inc  = starved ? CNT_MAX : starve_cnt_q + CNT_W'(1);

  // State and starvation counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Next-state, counter update and RAM/handshake outputs.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = bus.daddr;
    bus.ramstore = bus.dstore;
    bus.dwait    = 1'b1;
    bus.iwait    = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (starved && bus.iREN) begin
          state_d = IGRANT;
        end else if (d_req) begin
          state_d = DGRANT;
        end else if (bus.iREN) begin
          state_d = IGRANT;
        end
      end

      DGRANT: begin
        if (d_req) begin
          // A simultaneous read and write request issues the write.
          bus.ramWEN = bus.dWEN;
          bus.ramREN = bus.dREN & ~bus.dWEN;
          bus.dwait  = ~ram_done;
          if (ram_done && bus.iREN) begin
            starve_cnt_d = cnt_inc;
            // Hand the next slot to the icache once it has waited long enough.
            if (cnt_inc == CNT_MAX) begin
              state_d = IGRANT;
            end
          end
        end else begin
          // Dropped request: an empty cycle, then re-arbitrate.
          state_d = bus.iREN ? IGRANT : IDLE;
        end
      end

      IGRANT: begin
        bus.ramaddr = bus.iaddr;
        if (bus.iREN) begin
          bus.ramREN = 1'b1;
          bus.iwait  = ~ram_done;
          if (ram_done) begin
            starve_cnt_d = '0;
            if (d_req) begin
              state_d = DGRANT;
            end
          end
        end else begin
          state_d = d_req ? DGRANT : IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Nothing to protect when no fetch is pending.
    if (!bus.iREN) begin
      starve_cnt_d = '0;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a behavioural
// model of RAM ownership plus a starvation-bound invariant.
module tb_memory_arbiter;

  localparam int LIMIT = 4;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  // Owner codes used by the reference model.
  localparam int OWN_NONE = 0, OWN_DATA = 1, OWN_INSTR = 2;

  logic CLK;
  logic nRST;

  memory_arbiter_if bus ();

  memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: who holds the RAM, and how many data accesses have
  // completed while the current fetch has been waiting.
  int m_owner  = OWN_NONE;
  int m_served = 0;
  // Independent observation of the starvation guarantee.
  int waited   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against what the current owner should be doing.
  task automatic check_outputs();
    bit dq, d_on, i_on, done;
    dq   = bus.dREN | bus.dWEN;
    d_on = (m_owner == OWN_DATA) && dq;
    i_on = (m_owner == OWN_INSTR) && bus.iREN;
    done = (bus.ramstate == ACCESS);
    chk("dwait",    32'(bus.dwait),  32'(!(d_on && done)));
    chk("iwait",    32'(bus.iwait),  32'(!(i_on && done)));
    chk("ramWEN",   32'(bus.ramWEN), 32'(d_on && bus.dWEN));
    chk("ramREN",   32'(bus.ramREN), 32'((d_on && !bus.dWEN) || i_on));
    chk("ramaddr",  bus.ramaddr,  (m_owner == OWN_INSTR) ? bus.iaddr : bus.daddr);
    chk("ramstore", bus.ramstore, bus.dstore);
    chk("dload",    bus.dload,    bus.ramload);
    chk("iload",    bus.iload,    bus.ramload);
  endtask

  // Count data completions seen while one fetch stays pending and unserved.
  task automatic check_starvation();
    if (!bus.iREN || !bus.iwait) begin
      waited = 0;
    end else if (!bus.dwait) begin
      waited++;
      chk("starve_bound", 32'(waited <= LIMIT), 32'd1);
    end
  endtask

  // Decide next cycle's owner from the arbitration rules.
  function automatic void model_advance();
    bit dq, iq, done;
    int served_next;
    dq = bus.dREN | bus.dWEN;
    iq = bus.iREN;
    done = (bus.ramstate == ACCESS);
    served_next = m_served;
    if (m_owner == OWN_DATA && dq && done && iq)
      served_next = (m_served + 1 > LIMIT) ? LIMIT : m_served + 1;
    if (m_owner == OWN_INSTR && iq && done)
      served_next = 0;
    if (!iq)
      served_next = 0;

    case (m_owner)
      OWN_NONE: begin
        if (iq && m_served == LIMIT) m_owner = OWN_INSTR;
        else if (dq)                 m_owner = OWN_DATA;
        else if (iq)                 m_owner = OWN_INSTR;
      end
      OWN_DATA: begin
        if (!dq)                                     m_owner = iq ? OWN_INSTR : OWN_NONE;
        else if (done && iq && served_next == LIMIT) m_owner = OWN_INSTR;
      end
      default: begin
        if (!iq)       m_owner = dq ? OWN_DATA : OWN_NONE;
        else if (done) m_owner = dq ? OWN_DATA : OWN_INSTR;
      end
    endcase
    m_served = served_next;
  endfunction

  // One clock cycle: drive inputs, check mid-cycle, advance the model.
  task automatic cycle(input logic dr, input logic dw, input logic ir,
                       input logic [31:0] da, input logic [31:0] ia,
                       input logic [31:0] ds, input logic [1:0] rs);
    bus.dREN     = dr;
    bus.dWEN     = dw;
    bus.iREN     = ir;
    bus.daddr    = da;
    bus.iaddr    = ia;
    bus.dstore   = ds;
    bus.ramstate = rs;
    bus.ramload  = $urandom;
    @(negedge CLK);
    check_outputs();
    check_starvation();
    model_advance();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, FREE);
  endtask

  logic       r_dr, r_dw, r_ir;
  logic [1:0] r_rs;

  initial begin
    nRST = 1'b0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.iREN = 1'b0;
    bus.daddr = '0; bus.iaddr = '0; bus.dstore = '0;
    bus.ramload = '0; bus.ramstate = FREE;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_dwait",  32'(bus.dwait),  32'd1);
    chk("rst_iwait",  32'(bus.iwait),  32'd1);
    chk("rst_ramREN", 32'(bus.ramREN), 32'd0);
    chk("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
    nRST = 1'b1;

    // Data write burst, RAM latency 2, second word without a bubble.
    cycle(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 32'h1111_0000, FREE);
    cycle(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 32'h1111_0000, BUSY);
    cycle(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 32'h1111_0000, ACCESS);
    cycle(1'b0, 1'b1, 1'b0, 32'h104, 32'h0, 32'h2222_0000, BUSY);
    cycle(1'b0, 1'b1, 1'b0, 32'h104, 32'h0, 32'h2222_0000, ACCESS);
    idle_cycles(2);

    // Write wins over read.
    cycle(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 32'hDEAD_BEEF, FREE);
    cycle(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 32'hDEAD_BEEF, ACCESS);
    idle_cycles(2);

    // Simultaneous requests: data first, fetch after the dcache lets go.
    cycle(1'b1, 1'b0, 1'b1, 32'h300, 32'h400, 32'h0, FREE);
    cycle(1'b1, 1'b0, 1'b1, 32'h300, 32'h400, 32'h0, BUSY);
    cycle(1'b1, 1'b0, 1'b1, 32'h300, 32'h400, 32'h0, ACCESS);
    cycle(1'b0, 1'b0, 1'b1, 32'h300, 32'h400, 32'h0, FREE);
    cycle(1'b0, 1'b0, 1'b1, 32'h300, 32'h400, 32'h0, ACCESS);
    idle_cycles(2);

    // Icache read through BUSY, ERROR, BUSY, ACCESS.
    cycle(1'b0, 1'b0, 1'b1, 32'h0, 32'h500, 32'h0, FREE);
    cycle(1'b0, 1'b0, 1'b1, 32'h0, 32'h500, 32'h0, BUSY);
    cycle(1'b0, 1'b0, 1'b1, 32'h0, 32'h500, 32'h0, ERROR);
    cycle(1'b0, 1'b0, 1'b1, 32'h0, 32'h500, 32'h0, BUSY);
    cycle(1'b0, 1'b0, 1'b1, 32'h0, 32'h500, 32'h0, ACCESS);
    idle_cycles(2);

    // Starvation: continuous data reads with a fetch held pending.
    for (int k = 0; k < 14; k++)
      cycle(1'b1, 1'b0, 1'b1, 32'h600 + 32'(4 * k), 32'h700, 32'h0, ACCESS);
    idle_cycles(2);

    // Asynchronous reset in the middle of a stalled data access.
    cycle(1'b1, 1'b0, 1'b0, 32'h800, 32'h0, 32'h0, BUSY);
    bus.ramstate = BUSY;
    #2;
    chk("pre_rst_ramREN", 32'(bus.ramREN), 32'd1);
    nRST = 1'b0;
    #1;
    chk("async_ramREN", 32'(bus.ramREN), 32'd0);
    chk("async_ramWEN", 32'(bus.ramWEN), 32'd0);
    chk("async_dwait",  32'(bus.dwait),  32'd1);
    chk("async_iwait",  32'(bus.iwait),  32'd1);
    m_owner = OWN_NONE;
    m_served = 0;
    waited = 0;
    bus.dREN = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    idle_cycles(3);
    cycle(1'b1, 1'b0, 1'b0, 32'h900, 32'h0, 32'h0, ACCESS);
    cycle(1'b1, 1'b0, 1'b0, 32'h900, 32'h0, 32'h0, ACCESS);
    idle_cycles(2);

    // Randomized traffic with persistent requests.
    r_dr = 1'b0; r_dw = 1'b0; r_ir = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7) == 0) begin
        r_dr = ($urandom_range(99) < 70);
        r_dw = ($urandom_range(99) < 30);
        r_ir = ($urandom_range(99) < 70);
      end
      r_rs = ($urandom_range(9) < 4) ? ACCESS : 2'($urandom_range(3));
      cycle(r_dr, r_dw, r_ir, $urandom, $urandom, $urandom, r_rs);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
